// File: rtl/spi_shift_engine.sv
// Full-duplex SPI master shift engine: programmable SCLK divider, modes 0-3, MSB/LSB order.
// Optional build macro SPI_SHIFT_LOOPBACK_EN adds a LoopBack input (sample MOSI instead of MISO).
module spi_shift_engine #(
  parameter int unsigned Size     = 16,
  parameter int unsigned DivWidth = 8
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                Start,
  input  logic [Size-1:0]     TxData,
  input  logic [1:0]          SelectMode,
  input  logic                LsbFirst,
  input  logic [DivWidth-1:0] Div,
`ifdef SPI_SHIFT_LOOPBACK_EN
  input  logic                LoopBack,
`endif
  input  logic                MISO,
  output logic                SCLK,
  output logic                MOSI,
  output logic [Size-1:0]     RxData,
  output logic                Busy,
  output logic                Done
);

  localparam int unsigned CntW = $clog2(2 * Size);
  localparam logic [CntW-1:0] LastEdge = CntW'(2 * Size - 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, DONE} state_e;

  state_e              state_q;
  logic                cpol_q, cpha_q, lsb_q;
  logic [DivWidth-1:0] div_q, div_cnt_q;
  logic [CntW-1:0]     bit_cnt_q;
  logic [Size-1:0]     tx_q, rx_q;
`ifdef SPI_SHIFT_LOOPBACK_EN
  logic                lb_q;
`endif

  logic            half_done, leading, last_edge, sample_now, drive_now;
  logic            rx_in, tx_out, acc_first;
  logic [Size-1:0] rx_d, tx_shift, acc_shift;

  always_comb begin
    half_done = (div_cnt_q == div_q);
    leading   = ~bit_cnt_q[0];
    last_edge = (bit_cnt_q == LastEdge);
`ifdef SPI_SHIFT_LOOPBACK_EN
    rx_in = lb_q ? MOSI : MISO;
`else
    rx_in = MISO;
`endif
    // CPHA=0 samples on leading edges, CPHA=1 on trailing edges
    sample_now = half_done && (leading ^ cpha_q);
    drive_now  = half_done && (cpha_q ? leading : (~leading && ~last_edge));
    rx_d = rx_q;
    if (sample_now)
      rx_d = lsb_q ? {rx_in, rx_q[Size-1:1]} : {rx_q[Size-2:0], rx_in};
    tx_out    = lsb_q ? tx_q[0] : tx_q[Size-1];
    tx_shift  = lsb_q ? (tx_q >> 1) : (tx_q << 1);
    acc_first = LsbFirst ? TxData[0] : TxData[Size-1];
    acc_shift = LsbFirst ? (TxData >> 1) : (TxData << 1);
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q   <= IDLE;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      div_q     <= '0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
`ifdef SPI_SHIFT_LOOPBACK_EN
      lb_q      <= 1'b0;
`endif
      SCLK      <= 1'b0;
      MOSI      <= 1'b0;
      RxData    <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          SCLK <= SelectMode[1];
          if (Start) begin
            state_q   <= SETUP;
            cpol_q    <= SelectMode[1];
            cpha_q    <= SelectMode[0];
            lsb_q     <= LsbFirst;
            div_q     <= Div;
`ifdef SPI_SHIFT_LOOPBACK_EN
            lb_q      <= LoopBack;
`endif
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            Busy      <= 1'b1;
            // CPHA=0 must present the first bit before the first leading edge
            if (!SelectMode[0]) begin
              MOSI <= acc_first;
              tx_q <= acc_shift;
            end else begin
              tx_q <= TxData;
            end
          end
        end
        SETUP: begin
          SCLK <= cpol_q;
          if (half_done) begin
            state_q   <= XFER;
            div_cnt_q <= '0;
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end
        XFER: begin
          if (half_done) begin
            div_cnt_q <= '0;
            SCLK      <= ~SCLK;
            bit_cnt_q <= bit_cnt_q + 1'b1;
            rx_q      <= rx_d;
            if (drive_now) begin
              MOSI <= tx_out;
              tx_q <= tx_shift;
            end
            if (last_edge) begin
              state_q <= DONE;
              Done    <= 1'b1;
              RxData  <= rx_d;
            end
          end else begin
            div_cnt_q <= div_cnt_q + 1'b1;
          end
        end
        DONE: begin
          SCLK    <= cpol_q;
          Busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine (Size=8): a behavioural SPI slave watches SCLK,
// feeds MISO, captures MOSI and checks timing, data and handshake against SPI rules.
module tb_spi_shift_engine;

  logic       CLK = 1'b0;
  logic       Reset, Start, LsbFirst, MISO, SCLK, MOSI, Busy, Done;
  logic [7:0] TxData, Div, RxData;
  logic [1:0] SelectMode;
`ifdef SPI_SHIFT_LOOPBACK_EN
  logic       LoopBack = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  spi_shift_engine #(.Size(8), .DivWidth(8)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .TxData(TxData),
    .SelectMode(SelectMode), .LsbFirst(LsbFirst), .Div(Div),
`ifdef SPI_SHIFT_LOOPBACK_EN
    .LoopBack(LoopBack),
`endif
    .MISO(MISO), .SCLK(SCLK), .MOSI(MOSI), .RxData(RxData), .Busy(Busy), .Done(Done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // i-th bit on the wire for a given order
  function automatic logic wire_bit(input logic [7:0] w, input int i, input logic lsb);
    return lsb ? w[i] : w[7-i];
  endfunction

  // Called just after a negedge; Start is accepted at the following posedge (cycle 0).
  task automatic xfer(input logic [7:0] tx, input logic [7:0] mw, input logic [1:0] mode,
                      input logic lsb, input logic [7:0] dv, input int restart_at,
                      input bit start_on_done, input bit lb);
    logic       cpol, cpha, prev, leading;
    logic [7:0] got_mosi;
    int         edges, rises, nbits, k, done_cyc, limit;
    cpol = mode[1];
    cpha = mode[0];
    TxData = tx; SelectMode = mode; LsbFirst = lsb; Div = dv; Start = 1'b1;
`ifdef SPI_SHIFT_LOOPBACK_EN
    LoopBack = lb;
`endif
    k = cpha ? 0 : 1;
    MISO = (cpha || lb) ? 1'b0 : wire_bit(mw, 0, lsb);
    prev = cpol;
    edges = 0; rises = 0; nbits = 0; done_cyc = 0; got_mosi = '0;
    limit = 17 * (int'(dv) + 1) + 8;
    for (int c = 1; c <= limit && done_cyc == 0; c++) begin
      @(negedge CLK);
      if (c == 1) begin
        Start = 1'b0;
        chk("busy_after_accept", Busy, 1);
      end
      if (c == restart_at) begin
        Start = 1'b1; TxData = 8'hFF; SelectMode = ~mode; LsbFirst = ~lsb; Div = dv + 8'd3;
      end else if (c == restart_at + 1) begin
        Start = 1'b0;
      end
      if (SCLK !== prev) begin
        edges++;
        if (SCLK === 1'b1) rises++;
        leading = (SCLK !== cpol);
        if (leading ^ cpha) begin
          if (nbits < 8) got_mosi[lsb ? nbits : 7 - nbits] = MOSI;
          nbits++;
        end else begin
          if (k < 8 && !lb) MISO = wire_bit(mw, k, lsb);
          k++;
        end
        prev = SCLK;
      end
      if (Done === 1'b1) begin
        done_cyc = c;
        chk("busy_in_done", Busy, 1);
        chk("sclk_idle_at_done", SCLK, cpol);
        chk("rxdata", RxData, lb ? tx : mw);
        if (start_on_done) Start = 1'b1;
      end
    end
    chk("done_cycle", done_cyc, 17 * (int'(dv) + 1) + 1);
    chk("sclk_edges", edges, 16);
    chk("sclk_rises", rises, 8);
    chk("mosi_word", got_mosi, tx);
    @(negedge CLK);
    chk("busy_after_done", Busy, 0);
    chk("done_pulse_width", Done, 0);
    chk("rxdata_held", RxData, lb ? tx : mw);
  endtask

  initial begin
    Reset = 1'b0; Start = 1'b0; TxData = '0; SelectMode = '0; LsbFirst = 1'b0;
    Div = '0; MISO = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset_sclk", SCLK, 0);
    chk("reset_mosi", MOSI, 0);
    chk("reset_rxdata", RxData, 0);
    chk("reset_busy", Busy, 0);
    chk("reset_done", Done, 0);
    Reset = 1'b1;
    @(negedge CLK);

    xfer(8'hA5, 8'h3C, 2'd0, 1'b0, 8'd1, 0, 1'b0, 1'b0);
    xfer(8'h81, 8'hF0, 2'd3, 1'b1, 8'd0, 0, 1'b0, 1'b0);
    // retrigger mid-transfer ignored; Start on the Done cycle ignored, next cycle accepted
    xfer(8'h5A, 8'hC3, 2'd1, 1'b0, 8'd1, 5, 1'b1, 1'b0);
    xfer(8'h69, 8'h96, 2'd2, 1'b1, 8'd2, 0, 1'b0, 1'b0);

    // abort with reset mid-transfer in mode 2
    TxData = 8'hE7; SelectMode = 2'd2; LsbFirst = 1'b0; Div = 8'd1; Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    repeat (6) @(negedge CLK);
    Reset = 1'b0;
    @(negedge CLK);
    Reset = 1'b1;
    chk("abort_sclk", SCLK, 0);
    chk("abort_mosi", MOSI, 0);
    chk("abort_busy", Busy, 0);
    chk("abort_rxdata", RxData, 0);
    chk("abort_done", Done, 0);
    for (int i = 0; i < 40; i++) begin
      @(negedge CLK);
      if (Done === 1'b1 || Busy === 1'b1) begin
        chk("abort_stays_idle", {Busy, Done}, 0);
        break;
      end
    end
    chk("abort_idle_sclk_cpol", SCLK, 1);
    xfer(8'h3E, 8'hB1, 2'd2, 1'b0, 8'd1, 0, 1'b0, 1'b0);

    for (int n = 0; n < 12; n++) begin
      xfer(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom),
           8'($urandom_range(0, 3)), 0, 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

`ifdef SPI_SHIFT_LOOPBACK_EN
    xfer(8'h34, 8'hFF, 2'd0, 1'b0, 8'd1, 0, 1'b0, 1'b1);
    xfer(8'h12, 8'h00, 2'd3, 1'b1, 8'd0, 0, 1'b0, 1'b1);
`endif

    xfer(8'hC6, 8'h5D, 2'd0, 1'b0, 8'hFF, 0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
